// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
// Two-requester round-robin arbiter that drives the select of a downstream
// 2:1 mux and qualifies its output with a valid flag. A hold limit bounds
// how many accepted beats one source may take while the other is waiting.
// HOLD_MAX must lie in 1 .. 2**CNT_W-1.

module mux_sel_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic ready,
    output logic S,
    output logic gnt0,
    output logic gnt1,
    output logic valid
);

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             last_winner;
    logic             next_last;
    logic             beat;
    logic             at_limit;

    // A beat is an accepted transfer; valid is registered, so this has no
    // combinational path from inputs to outputs.
    assign beat     = valid & ready;
    assign at_limit = (hold_cnt == HOLD_LAST);

    // Next-state, hold-counter and fairness bookkeeping for the grant FSM.
    always_comb begin
        next_state = state;
        next_cnt   = hold_cnt;
        next_last  = last_winner;

        if (beat && !at_limit) begin
            next_cnt = hold_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    next_state = last_winner ? GNT0 : GNT1;
                end else if (req0) begin
                    next_state = GNT0;
                end else if (req1) begin
                    next_state = GNT1;
                end
            end

            GNT0: begin
                if (!req0) begin
                    next_state = req1 ? GNT1 : IDLE;
                    next_last  = 1'b0;
                    next_cnt   = '0;
                end else if (beat && at_limit && req1) begin
                    next_state = GNT1;
                    next_last  = 1'b0;
                    next_cnt   = '0;
                end
            end

            GNT1: begin
                if (!req1) begin
                    next_state = req0 ? GNT0 : IDLE;
                    next_last  = 1'b1;
                    next_cnt   = '0;
                end else if (beat && at_limit && req0) begin
                    next_state = GNT0;
                    next_last  = 1'b1;
                    next_cnt   = '0;
                end
            end

            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    // State register with outputs decoded from the next state, so the mux
    // select, both grants and valid all change together on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            last_winner <= 1'b1;
            S           <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            valid       <= 1'b0;
        end else begin
            state       <= next_state;
            hold_cnt    <= next_cnt;
            last_winner <= next_last;
            S           <= (next_state == GNT1);
            gnt0        <= (next_state == GNT0);
            gnt1        <= (next_state == GNT1);
            valid       <= (next_state != IDLE);
        end
    end

endmodule
